// File: rtl/t1_sim_ctrl_fsm.sv
// Simulation-control sequencer: init flag, cycle count, watchdog interpretation,
// drain-to-idle after quit, global/idle timeouts and wave-dump window gating.
module t1_sim_ctrl_fsm #(
    parameter int         CYCLE_W     = 64,
    parameter int         INIT_CYCLES = 1,
    parameter logic [7:0] QUIT_CODE   = 8'd255
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [CYCLE_W-1:0] cfg_global_timeout,
    input  logic [CYCLE_W-1:0] cfg_quit_timeout,
    input  logic [CYCLE_W-1:0] cfg_dump_start,
    input  logic [CYCLE_W-1:0] cfg_dump_end,
    input  logic               wd_valid,
    input  logic [7:0]         wd_status,
    input  logic               idle,
    output logic               initFlag,
    output logic               wd_poll,
    output logic               dump_en,
    output logic [CYCLE_W-1:0] cycle,
    output logic [CYCLE_W-1:0] quit_cycle,
    output logic               done,
    output logic               fail,
    output logic [1:0]         fail_code
);

    // state  | meaning
    // INIT   | init phase, initFlag high for INIT_CYCLES edges
    // RUN    | watchdog polled every cycle
    // DRAIN  | quit seen, waiting for idle or quit timeout
    // PASS   | simulation passed, absorbing
    // FAIL   | simulation failed, fail_code held, absorbing
    typedef enum logic [2:0] {
        ST_INIT,
        ST_RUN,
        ST_DRAIN,
        ST_PASS,
        ST_FAIL
    } state_e;

    localparam int ICW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;

    state_e             state_q, state_d;
    logic [ICW-1:0]     init_cnt_q, init_cnt_d;
    logic [CYCLE_W-1:0] cycle_q, cycle_d;
    logic [CYCLE_W-1:0] quit_cycle_q, quit_cycle_d;
    logic [1:0]         fail_code_q, fail_code_d;
    logic               init_flag_q, dump_en_q, done_q, fail_q;
    logic               dump_en_d;
    logic               global_to, idle_to, wd_quit, wd_err;
    logic [CYCLE_W:0]   drain_limit;

    always_comb begin
        state_d      = state_q;
        init_cnt_d   = init_cnt_q;
        quit_cycle_d = quit_cycle_q;
        fail_code_d  = fail_code_q;
        cycle_d      = (&cycle_q) ? cycle_q : cycle_q + CYCLE_W'(1);

        global_to   = (cfg_global_timeout != '0) && (cycle_q == cfg_global_timeout);
        // one extra bit so quit_cycle + timeout cannot wrap
        drain_limit = {1'b0, quit_cycle_q} + {1'b0, cfg_quit_timeout};
        idle_to     = {1'b0, cycle_q} > drain_limit;
        wd_quit     = wd_valid && (wd_status == QUIT_CODE);
        wd_err      = wd_valid && (wd_status != 8'd0) && (wd_status != QUIT_CODE);

        case (state_q)
            ST_INIT: begin
                if (init_cnt_q == ICW'(INIT_CYCLES - 1)) state_d = ST_RUN;
                else                                     init_cnt_d = init_cnt_q + ICW'(1);
            end
            ST_RUN: begin
                if (wd_err) begin
                    state_d     = ST_FAIL;
                    fail_code_d = 2'd1;
                end else if (wd_quit) begin
                    quit_cycle_d = cycle_q;
                    state_d      = idle ? ST_PASS : ST_DRAIN;
                end else if (global_to) begin
                    state_d     = ST_FAIL;
                    fail_code_d = 2'd3;
                end
            end
            ST_DRAIN: begin
                if (idle) begin
                    state_d = ST_PASS;
                end else if (idle_to) begin
                    state_d     = ST_FAIL;
                    fail_code_d = 2'd2;
                end else if (global_to) begin
                    state_d     = ST_FAIL;
                    fail_code_d = 2'd3;
                end
            end
            default: state_d = state_q;
        endcase

        dump_en_d = (state_d != ST_PASS) && (state_d != ST_FAIL) &&
                    (cycle_d >= cfg_dump_start) &&
                    ((cfg_dump_end == '0) || (cycle_d < cfg_dump_end));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_INIT;
            init_cnt_q   <= '0;
            cycle_q      <= '0;
            quit_cycle_q <= '0;
            fail_code_q  <= 2'd0;
            init_flag_q  <= 1'b1;
            dump_en_q    <= 1'b0;
            done_q       <= 1'b0;
            fail_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            init_cnt_q   <= init_cnt_d;
            cycle_q      <= cycle_d;
            quit_cycle_q <= quit_cycle_d;
            fail_code_q  <= fail_code_d;
            init_flag_q  <= (state_d == ST_INIT);
            dump_en_q    <= dump_en_d;
            done_q       <= (state_d == ST_PASS);
            fail_q       <= (state_d == ST_FAIL);
        end
    end

    assign wd_poll    = (state_q == ST_RUN);
    assign initFlag   = init_flag_q;
    assign dump_en    = dump_en_q;
    assign cycle      = cycle_q;
    assign quit_cycle = quit_cycle_q;
    assign done       = done_q;
    assign fail       = fail_q;
    assign fail_code  = fail_code_q;

endmodule

// File: tb/tb_t1_sim_ctrl_fsm.sv
// Directed-vector bench for t1_sim_ctrl_fsm with hand-computed expectations.
module tb_t1_sim_ctrl_fsm;

    logic        clock;
    logic        reset;
    logic [63:0] cfg_global_timeout;
    logic [63:0] cfg_quit_timeout;
    logic [63:0] cfg_dump_start;
    logic [63:0] cfg_dump_end;
    logic        wd_valid;
    logic [7:0]  wd_status;
    logic        idle;
    logic        initFlag;
    logic        wd_poll;
    logic        dump_en;
    logic [63:0] cycle;
    logic [63:0] quit_cycle;
    logic        done;
    logic        fail;
    logic [1:0]  fail_code;

    int nvec = 0;
    int nmis = 0;
    int cyc  = 0;

    t1_sim_ctrl_fsm #(.CYCLE_W(64), .INIT_CYCLES(1), .QUIT_CODE(8'd255)) dut (
        .clock              (clock),
        .reset              (reset),
        .cfg_global_timeout (cfg_global_timeout),
        .cfg_quit_timeout   (cfg_quit_timeout),
        .cfg_dump_start     (cfg_dump_start),
        .cfg_dump_end       (cfg_dump_end),
        .wd_valid           (wd_valid),
        .wd_status          (wd_status),
        .idle               (idle),
        .initFlag           (initFlag),
        .wd_poll            (wd_poll),
        .dump_en            (dump_en),
        .cycle              (cycle),
        .quit_cycle         (quit_cycle),
        .done               (done),
        .fail               (fail),
        .fail_code          (fail_code)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        if (obs !== exp) begin
            nmis++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) tick();
    endtask

    // Applies reset with the given config; on return cycle 0 is showing, reset released.
    task automatic do_reset(input logic [63:0] gto, input logic [63:0] qto,
                            input logic [63:0] dstart, input logic [63:0] dend);
        reset              = 1'b1;
        cfg_global_timeout = gto;
        cfg_quit_timeout   = qto;
        cfg_dump_start     = dstart;
        cfg_dump_end       = dend;
        wd_valid           = 1'b1;
        wd_status          = 8'd0;
        idle               = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        cyc   = 0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".initFlag"},   initFlag,   1);
        chk({tag, ".wd_poll"},    wd_poll,    0);
        chk({tag, ".dump_en"},    dump_en,    0);
        chk({tag, ".cycle"},      cycle,      0);
        chk({tag, ".quit_cycle"}, quit_cycle, 0);
        chk({tag, ".done"},       done,       0);
        chk({tag, ".fail"},       fail,       0);
        chk({tag, ".fail_code"},  fail_code,  0);
    endtask

    initial begin
        // normal pass
        do_reset(64'd0, 64'd100, 64'd0, 64'd0);
        chk_reset_vals("rst");
        tick();
        chk("np.cycle1",    cycle,    1);
        chk("np.initFlag1", initFlag, 0);
        chk("np.wd_poll1",  wd_poll,  1);
        chk("np.dump_en1",  dump_en,  1);
        run_to(50);
        chk("np.done50", done, 0);
        wd_status = 8'd255;
        idle      = 1'b1;
        tick();
        chk("np.cycle51",   cycle,      51);
        chk("np.done51",    done,       1);
        chk("np.quit",      quit_cycle, 50);
        chk("np.fail",      fail,       0);
        chk("np.dump_off",  dump_en,    0);
        chk("np.poll_off",  wd_poll,    0);
        wd_status = 8'd7;
        run_to(55);
        chk("np.sticky",    done,       1);
        chk("np.nofail",    fail,       0);

        // drain then pass; error status after quit must be ignored
        do_reset(64'd0, 64'd100, 64'd0, 64'd0);
        run_to(20);
        wd_status = 8'd255;
        tick();
        chk("dr.poll21",  wd_poll,    0);
        chk("dr.quit",    quit_cycle, 20);
        chk("dr.done21",  done,       0);
        wd_status = 8'd7;
        run_to(30);
        chk("dr.done30",  done,       0);
        chk("dr.fail30",  fail,       0);
        idle = 1'b1;
        tick();
        chk("dr.done31",  done,       1);
        chk("dr.fail31",  fail,       0);

        // idle timeout: quit at 20, limit 25, cycle 26 exceeds it
        do_reset(64'd0, 64'd5, 64'd0, 64'd0);
        run_to(20);
        wd_status = 8'd255;
        tick();
        wd_valid = 1'b0;
        run_to(26);
        chk("it.fail26",  fail,      0);
        tick();
        chk("it.fail27",  fail,      1);
        chk("it.code",    fail_code, 2);
        chk("it.done",    done,      0);
        run_to(30);
        chk("it.sticky",  fail_code, 2);

        // watchdog error beats global timeout on the same cycle
        do_reset(64'd10, 64'd100, 64'd0, 64'd0);
        run_to(10);
        wd_status = 8'd7;
        tick();
        chk("pr.fail",    fail,      1);
        chk("pr.code",    fail_code, 1);
        chk("pr.done",    done,      0);

        // quit with idle beats global timeout
        do_reset(64'd10, 64'd100, 64'd0, 64'd0);
        run_to(10);
        wd_status = 8'd255;
        idle      = 1'b1;
        tick();
        chk("pq.done",    done,      1);
        chk("pq.fail",    fail,      0);

        // plain global timeout
        do_reset(64'd10, 64'd100, 64'd0, 64'd0);
        run_to(10);
        chk("gt.fail10",  fail,      0);
        tick();
        chk("gt.fail11",  fail,      1);
        chk("gt.code",    fail_code, 3);

        // dump window 5..8
        do_reset(64'd0, 64'd100, 64'd5, 64'd9);
        for (int i = 1; i <= 12; i++) begin
            tick();
            chk("dw.5_9", dump_en, ((cyc >= 5) && (cyc < 9)) ? 1 : 0);
        end

        // end <= start: never asserted
        do_reset(64'd0, 64'd100, 64'd9, 64'd5);
        for (int i = 1; i <= 12; i++) begin
            tick();
            chk("dw.empty", dump_en, 0);
        end

        // async reset mid-DRAIN
        do_reset(64'd0, 64'd100, 64'd0, 64'd0);
        run_to(20);
        wd_status = 8'd255;
        tick();
        wd_valid = 1'b0;
        run_to(25);
        chk("ar.poll25", wd_poll, 0);
        #2;
        reset = 1'b1;
        #1;
        chk_reset_vals("ar");
        @(posedge clock);
        #1;
        reset = 1'b0;
        cyc   = 0;
        chk("ar.cycle0",   cycle,    0);
        chk("ar.init0",    initFlag, 1);
        wd_valid  = 1'b1;
        wd_status = 8'd0;
        tick();
        chk("ar.cycle1",   cycle,    1);
        chk("ar.init1",    initFlag, 0);
        chk("ar.poll1",    wd_poll,  1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
